fact_bcd_conv: RTL and testbench
================================

FACT_BCD_CONV -- requirements
Module: fact_bcd_conv

Interface
REQ-001 Parameters: none; the block is fixed at a 16-bit binary input and 5 BCD digits.
REQ-002 One clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 y  input  16  unsigned binary value from the factorial stage; sampled only on an accepted start.
REQ-006 start  input  1  conversion request; accepted only in IDLE.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when a new result is loaded into bcd.
REQ-009 bcd  output  20  five packed BCD digits; [19:16] is ten-thousands and [3:0] is units.
REQ-010 blank  output  5  per-digit leading-zero blank flags; blank[i] pairs with bcd[4i+3:4i].

Function
REQ-011 FSM states are IDLE and SHIFT; the reset state is IDLE.
REQ-012 IDLE with start=1 at a clock edge (edge 0):
  - capture y into the shift register;
  - clear the 20-bit BCD scratch register;
  - clear the 5-bit shift counter;
  - assert busy;
  - go to SHIFT.
REQ-013 SHIFT, each edge (edges 1..16):
  - add 3 to every scratch digit that is >=5;
  - then shift {scratch, shift register} left 1 bit;
  - increment the counter.
REQ-014 At the 16th shift edge (edge 16):
  - load bcd with the final scratch value;
  - update blank;
  - set done=1 for exactly one cycle;
  - deassert busy;
  - return to IDLE.
REQ-015 Latency is fixed at 16 cycles from the accepted start to done, independent of the value of y.
REQ-016 start while busy=1 is ignored; y changes while busy=1 have no effect.
REQ-017 start=1 in the cycle where done=1 is accepted (state is IDLE); back-to-back throughput is one result per 17 cycles.
REQ-018 bcd and blank hold the last completed result until the next completion; they never show partial values.
REQ-019 Every bcd digit is in 0..9 for all 16-bit inputs; 65535 maps to 0x65535 and 0 maps to 0x00000.
REQ-020 start held high continuously starts a new conversion at every IDLE entry.

Reset
REQ-021 rst_n=0 asynchronously forces:
  - state=IDLE, busy=0, done=0;
  - bcd=20'h00000, blank=5'b00000;
  - scratch, shift register and counter to 0.
REQ-022 Reset during SHIFT aborts the conversion; no done is produced for it, and the first start after rst_n rises begins a fresh conversion.
REQ-023 rst_n deassertion is synchronised externally; the block assumes no recovery/removal violation.

Configuration
REQ-024 Macro FACT_BCD_BLANK_EN controls leading-zero blanking.
REQ-025 With FACT_BCD_BLANK_EN defined:
  - at load, blank[i]=1 (i=1..4) iff digit i and all higher digits are zero;
  - blank[0] is always 0.
REQ-026 Without FACT_BCD_BLANK_EN, the blank port still exists but is tied to 5'b00000 and holds no flip-flops.

Verification
REQ-027 Scenario: reset, then y=5040, start pulse -> done exactly 16 cycles later, bcd=20'h05040, blank=5'b10000 (macro on) or 5'b00000 (macro off), busy high for those 16 cycles.
REQ-028 Scenario: y=0, then y=65535, one after the other -> bcd=20'h00000 with blank=5'b11110 (macro on); then bcd=20'h65535 with blank=5'b00000.
REQ-029 Scenario: sweep y over 1,2,6,24,120,720,5040 with start re-asserted in each done cycle -> bcd=0x00001,0x00002,0x00006,0x00024,0x00120,0x00720,0x05040, one done per 17 cycles.
REQ-030 Scenario: y=720 started, then start=1 with y=24 on cycle 5 while busy -> second request ignored, result bcd=20'h00720, single done.
REQ-031 Scenario: y=5040 started, rst_n=0 on cycle 8 -> busy, done, bcd and blank clear immediately, no done afterwards; a new start with y=6 gives bcd=20'h00006 16 cycles later.
REQ-032 Scenario: random 16-bit y, 1000 iterations, compared against a behavioural decimal model -> zero mismatches and every digit <=9.

Source files
------------

// File: rtl/fact_bcd_conv.sv
// fact_bcd_conv: 16-bit binary to 5-digit packed BCD converter (double-dabble, one bit per cycle).
// Latency: fixed 16 cycles from accepted start to done; one result per 17 cycles back-to-back.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   y      - 16-bit unsigned input, sampled on accepted start
//   start  - conversion request
//   busy   - conversion in progress
//   done   - one-cycle pulse when bcd/blank are updated
//   bcd    - five packed BCD digits, [19:16] ten-thousands .. [3:0] units
//   blank  - per-digit leading-zero blank flags (blank[i] pairs with bcd[4i+3:4i])
//
// Build option: define FACT_BCD_BLANK_EN to enable leading-zero blanking; otherwise
// blank is tied to zero and has no storage.
module fact_bcd_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] y,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [4:0]  blank
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_last;

    logic [15:0] r_shift;
    logic [19:0] r_scratch;
    logic [4:0]  r_cnt;
    logic [19:0] r_bcd;
    logic        r_done;

    logic [19:0] w_adj;
    logic [19:0] w_scratch_nxt;
    logic        w_unused_msb;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Counter still holds 15 while the 16th shift is being applied.
                if (r_cnt == 5'd15) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to any digit >= 5, then shift left one bit
    // with the next binary MSB entering the units digit.
    // ------------------------------------------------------------------
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 5; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_scratch_nxt = {w_adj[18:0], r_shift[15]};
    // A 16-bit input never exceeds 65535, so the top scratch bit is never set
    // before the final shift and drops out harmlessly.
    assign w_unused_msb  = w_adj[19];

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 16'h0000;
            r_scratch <= 20'h00000;
            r_cnt     <= 5'd0;
            r_bcd     <= 20'h00000;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shift   <= y;
                r_scratch <= 20'h00000;
                r_cnt     <= 5'd0;
            end else if (r_state == SHIFT) begin
                r_shift   <= {r_shift[14:0], 1'b0};
                r_scratch <= w_scratch_nxt;
                r_cnt     <= r_cnt + 5'd1;
            end
            // Output register updates only on completion, so partial
            // scratch values are never visible.
            if (w_last) begin
                r_bcd <= w_scratch_nxt;
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = r_done;
    assign bcd  = r_bcd;

    // ------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------
`ifdef FACT_BCD_BLANK_EN
    logic [4:0] r_blank;
    logic [4:0] w_blank_nxt;

    // blank[i] is set when digit i and every higher digit are zero; the
    // units digit is always shown.
    always_comb begin
        w_blank_nxt    = 5'b00000;
        w_blank_nxt[4] = (w_scratch_nxt[19:16] == 4'd0);
        w_blank_nxt[3] = w_blank_nxt[4] && (w_scratch_nxt[15:12] == 4'd0);
        w_blank_nxt[2] = w_blank_nxt[3] && (w_scratch_nxt[11:8]  == 4'd0);
        w_blank_nxt[1] = w_blank_nxt[2] && (w_scratch_nxt[7:4]   == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= 5'b00000;
        end else if (w_last) begin
            r_blank <= w_blank_nxt;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 5'b00000;
`endif

endmodule

// File: tb/tb_fact_bcd_conv.sv
// tb_fact_bcd_conv: directed and random checks of fact_bcd_conv.
// Latency under test: 16 cycles start-to-done, 17-cycle back-to-back spacing.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_fact_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic [15:0] y;
    logic        start;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    int n_cmp;
    int n_bad;
    int cyc;

    fact_bcd_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef FACT_BCD_BLANK_EN
    localparam logic [4:0] BLK_5040 = 5'b10000;
    localparam logic [4:0] BLK_ZERO = 5'b11110;
`else
    localparam logic [4:0] BLK_5040 = 5'b00000;
    localparam logic [4:0] BLK_ZERO = 5'b00000;
`endif

    // Behavioural decimal model.
    function automatic logic [19:0] model_bcd(input int v);
        logic [19:0] r;
        int t;
        r = 20'h00000;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input logic [19:0] b);
        logic [4:0] r;
        logic z;
        r = 5'b00000;
        z = 1'b1;
`ifdef FACT_BCD_BLANK_EN
        for (int i = 4; i >= 1; i--) begin
            z = z && (b[4*i +: 4] == 4'd0);
            r[i] = z;
        end
`else
        z = b[0];
`endif
        return r;
    endfunction

    // Pulse start with val, then wait (bounded) for done. Leaves the bench
    // 1ns after the done edge so the caller may restart in the done cycle.
    task automatic do_conv(input logic [15:0] val, output int lat,
                           output int busy_n, output int held_bad);
        logic [19:0] prev;
        prev     = bcd;
        start    = 1'b1;
        y        = val;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_n   = busy ? 1 : 0;
        held_bad = 0;
        lat      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                break;
            end
            if (bcd !== prev) held_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        y     = 16'h0000;
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_ctl got=%b exp=00", {busy, done}); end
        n_cmp++; if (bcd !== 20'h00000) begin n_bad++; $display("FAIL reset_bcd got=%h exp=00000", bcd); end
        n_cmp++; if (blank !== 5'b00000) begin n_bad++; $display("FAIL reset_blank got=%b exp=00000", blank); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_basic();
        int lat, bn, hb;
        do_conv(16'd5040, lat, bn, hb);
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL basic_latency got=%0d exp=16", lat); end
        n_cmp++; if (bn !== 16) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=16", bn); end
        n_cmp++; if (bcd !== 20'h05040) begin n_bad++; $display("FAIL basic_bcd got=%h exp=05040", bcd); end
        n_cmp++; if (blank !== BLK_5040) begin n_bad++; $display("FAIL basic_blank got=%b exp=%b", blank, BLK_5040); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_max();
        int lat, bn, hb;
        do_conv(16'd0, lat, bn, hb);
        n_cmp++; if (bcd !== 20'h00000) begin n_bad++; $display("FAIL zero_bcd got=%h exp=00000", bcd); end
        n_cmp++; if (blank !== BLK_ZERO) begin n_bad++; $display("FAIL zero_blank got=%b exp=%b", blank, BLK_ZERO); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL zero_latency got=%0d exp=16", lat); end
        do_conv(16'd65535, lat, bn, hb);
        n_cmp++; if (bcd !== 20'h65535) begin n_bad++; $display("FAIL max_bcd got=%h exp=65535", bcd); end
        n_cmp++; if (blank !== 5'b00000) begin n_bad++; $display("FAIL max_blank got=%b exp=00000", blank); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL max_latency got=%0d exp=16", lat); end
        n_cmp++; if (hb !== 0) begin n_bad++; $display("FAIL max_hold_partial got=%0d exp=0", hb); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [7];
        logic [19:0] exps [7];
        int lat, bn, hb, last_cyc;
        vals = '{16'd1, 16'd2, 16'd6, 16'd24, 16'd120, 16'd720, 16'd5040};
        exps = '{20'h00001, 20'h00002, 20'h00006, 20'h00024, 20'h00120, 20'h00720, 20'h05040};
        last_cyc = 0;
        for (int i = 0; i < 7; i++) begin
            do_conv(vals[i], lat, bn, hb);
            n_cmp++; if (bcd !== exps[i]) begin n_bad++; $display("FAIL b2b_bcd[%0d] got=%h exp=%h", i, bcd, exps[i]); end
            n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=16", i, lat); end
            if (i > 0) begin
                n_cmp++; if (cyc - last_cyc !== 17) begin n_bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=17", i, cyc - last_cyc); end
            end
            last_cyc = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int ndone, lat;
        ndone = 0;
        lat   = 0;
        start = 1'b1;
        y     = 16'd720;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if (k == 5) begin
                start = 1'b1;
                y     = 16'd24;
            end else if (k == 6) begin
                start = 1'b0;
            end
            if (k > 6 && k < 15) y = 16'($urandom_range(0, 65535));
        end
        n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=16", lat); end
        n_cmp++; if (bcd !== 20'h00720) begin n_bad++; $display("FAIL ignore_bcd got=%h exp=00720", bcd); end
    endtask

    task automatic test_reset_abort();
        int ndone, lat, bn, hb;
        start = 1'b1;
        y     = 16'd5040;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL abort_ctl got=%b exp=00", {busy, done}); end
        n_cmp++; if (bcd !== 20'h00000) begin n_bad++; $display("FAIL abort_bcd got=%h exp=00000", bcd); end
        n_cmp++; if (blank !== 5'b00000) begin n_bad++; $display("FAIL abort_blank got=%b exp=00000", blank); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        do_conv(16'd6, lat, bn, hb);
        n_cmp++; if (bcd !== 20'h00006) begin n_bad++; $display("FAIL abort_restart_bcd got=%h exp=00006", bcd); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL abort_restart_latency got=%0d exp=16", lat); end
    endtask

    task automatic test_start_held();
        int ndone, last_k;
        ndone  = 0;
        last_k = 0;
        @(posedge clk); #1;
        start = 1'b1;
        y     = 16'd120;
        @(posedge clk); #1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                last_k = k;
            end
            if (k >= 34) start = 1'b0;
        end
        n_cmp++; if (ndone !== 3) begin n_bad++; $display("FAIL held_done_count got=%0d exp=3", ndone); end
        n_cmp++; if (last_k !== 50) begin n_bad++; $display("FAIL held_last_done got=%0d exp=50", last_k); end
        n_cmp++; if (bcd !== 20'h00120) begin n_bad++; $display("FAIL held_bcd got=%h exp=00120", bcd); end
    endtask

    task automatic test_random();
        int lat, bn, hb, bad_dig;
        logic [15:0] v;
        logic [19:0] eb;
        for (int it = 0; it < 1000; it++) begin
            v  = 16'($urandom_range(0, 65535));
            eb = model_bcd(int'(v));
            do_conv(v, lat, bn, hb);
            n_cmp++; if (bcd !== eb) begin n_bad++; $display("FAIL rand_bcd y=%0d got=%h exp=%h", v, bcd, eb); end
            n_cmp++; if (blank !== model_blank(eb)) begin n_bad++; $display("FAIL rand_blank y=%0d got=%b exp=%b", v, blank, model_blank(eb)); end
            n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL rand_latency y=%0d got=%0d exp=16", v, lat); end
            bad_dig = 0;
            for (int d = 0; d < 5; d++) begin
                if (bcd[4*d +: 4] > 4'd9) bad_dig++;
            end
            n_cmp++; if (bad_dig !== 0) begin n_bad++; $display("FAIL rand_digit_range y=%0d got=%0d bad digits exp=0", v, bad_dig); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        test_reset();
        test_basic();
        test_zero_max();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_start_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
